// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I core sequenced by an FSM, with req/ack instruction and data
// ports, a per-request bus timeout that parks the core in a sticky fault, debug halt and instret.
module cpu_mc #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUS_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ack,
    input  logic [31:0]      dmem_rdata,
    input  logic             halt_i,
    output logic             halted_o,
    output logic             fault_o,
    output logic             retire_o,
    output logic [31:0]      pc_o,
    output logic [CNT_W-1:0] instret_o
);
    typedef enum logic [2:0] {BOOT, FETCH, EXEC, MEM, HALT, FAULT} state_t;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

    state_t state, state_nxt;
    logic [31:0] pc, ir, pc_nxt, wb_data, alu_y, mem_addr, st_data;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rf [0:31];
    logic [15:0] tmo_cnt;
    logic [CNT_W-1:0] instret;
    logic fault, commit, rf_we, is_load, is_store, tmo_hit, alu_alt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  alu_f = alt ? a - b : a + b;
            3'b001:  alu_f = a << b[4:0];
            3'b010:  alu_f = {31'b0, sa < sb};
            3'b011:  alu_f = {31'b0, a < b};
            3'b100:  alu_f = a ^ b;
            3'b101: begin
                if (alt) alu_f = sa >>> b[4:0];
                else     alu_f = a >> b[4:0];
            end
            3'b110:  alu_f = a | b;
            default: alu_f = a & b;
        endcase
    endfunction

    function automatic logic br_take(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  br_take = (a == b);
            3'b001:  br_take = (a != b);
            3'b100:  br_take = (sa < sb);
            3'b101:  br_take = (sa >= sb);
            3'b110:  br_take = (a < b);
            3'b111:  br_take = (a >= b);
            default: br_take = 1'b0;
        endcase
    endfunction

    // Sub-word loads pick their lane by the low address bits, then extend.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {ofs, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'b0, sh[7:0]};
            3'b101:  load_ext = {16'b0, sh[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_v  = rf[rs1];
    assign rs2_v  = rf[rs2];

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign alu_alt  = ir[30] && (opcode == OP_OP || funct3 == 3'b101);
    assign alu_y    = alu_f(funct3, alu_alt, rs1_v, (opcode == OP_OP) ? rs2_v : imm_i);
    assign mem_addr = rs1_v + (is_store ? imm_s : imm_i);
    assign st_data  = (funct3[1:0] == 2'b00) ? {4{rs2_v[7:0]}} :
                      (funct3[1:0] == 2'b01) ? {2{rs2_v[15:0]}} : rs2_v;

    always_comb begin
        pc_nxt = pc + 32'd4;
        case (opcode)
            OP_JAL:    pc_nxt = pc + imm_j;
            OP_JALR:   pc_nxt = (rs1_v + imm_i) & ~32'd1;
            OP_BRANCH: if (br_take(funct3, rs1_v, rs2_v)) pc_nxt = pc + imm_b;
            default:   ;
        endcase
    end

    always_comb begin
        wb_data = alu_y;
        rf_we   = 1'b0;
        case (opcode)
            OP_LUI:          begin wb_data = imm_u;       rf_we = 1'b1; end
            OP_AUIPC:        begin wb_data = pc + imm_u;  rf_we = 1'b1; end
            OP_JAL, OP_JALR: begin wb_data = pc + 32'd4;  rf_we = 1'b1; end
            OP_OP, OP_IMM:   rf_we = 1'b1;
            OP_LOAD: begin
                wb_data = load_ext(funct3, mem_addr[1:0], dmem_rdata);
                rf_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // The timeout fires on the BUS_TIMEOUT-th consecutive cycle without ack.
    assign tmo_hit = (BUS_TIMEOUT != 0) && (({1'b0, tmo_cnt} + 17'd1) == 17'(BUS_TIMEOUT));

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (imem_ack)     state_nxt = EXEC;
                else if (tmo_hit) state_nxt = FAULT;
            end
            EXEC: begin
                if (is_load || is_store) state_nxt = MEM;
                else begin
                    commit    = 1'b1;
                    state_nxt = halt_i ? HALT : FETCH;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    commit    = 1'b1;
                    state_nxt = halt_i ? HALT : FETCH;
                end else if (tmo_hit) state_nxt = FAULT;
            end
            HALT:    if (!halt_i) state_nxt = FETCH;
            FAULT:   ;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            ir      <= '0;
            tmo_cnt <= '0;
            instret <= '0;
            fault   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack) ir <= imem_rdata;
            if ((state == FETCH || state == MEM) && state_nxt == state) tmo_cnt <= tmo_cnt + 16'd1;
            else tmo_cnt <= '0;
            if (state_nxt == FAULT) fault <= 1'b1;
            if (commit) begin
                pc      <= pc_nxt;
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (commit && rf_we && rd != 5'd0) begin
            rf[rd] <= wb_data;
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = imem_req ? pc : '0;
    assign dmem_req   = (state == MEM);
    assign dmem_we    = dmem_req && is_store;
    assign dmem_addr  = dmem_req ? mem_addr : '0;
    assign dmem_wdata = dmem_we ? st_data : '0;
    assign halted_o   = (state == HALT);
    assign fault_o    = fault;
    assign retire_o   = commit;
    assign pc_o       = pc;
    assign instret_o  = instret;
endmodule

// File: tb/tb_cpu_mc.sv
`timescale 1ns/1ps
// Directed bench for cpu_mc: ROM/RAM responders with programmable wait states drive a short
// RV32I program; per-instruction expectations live in a table, corner cases are hand sequences.
module tb_cpu_mc;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        halt_i, halted_o, fault_o, retire_o;
    logic [31:0] pc_o, instret_o;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:63] = '{default: '0};
    int i_wait, d_wait;
    int iw_cnt = 0;
    int dw_cnt = 0;
    bit d_en, d_force;
    int n_chk, n_pass, n_ret;

    typedef struct {
        logic [31:0] pc;
        int          base;
        bit          mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc_nxt;
    } vec_t;
    vec_t tbl [0:10];

    always #5 clk = ~clk;

    cpu_mc #(.RESET_PC(RST_PC), .BUS_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halt_i(halt_i), .halted_o(halted_o), .fault_o(fault_o), .retire_o(retire_o),
        .pc_o(pc_o), .instret_o(instret_o)
    );

    assign imem_rdata = rom[imem_addr[7:2]];
    assign imem_ack   = imem_req && (iw_cnt >= i_wait);
    assign dmem_rdata = ram[dmem_addr[7:2]];
    assign dmem_ack   = (dmem_req && d_en && (dw_cnt >= d_wait)) || d_force;

    always @(posedge clk) begin
        iw_cnt <= (imem_req && !imem_ack) ? iw_cnt + 1 : 0;
        dw_cnt <= (dmem_req && !dmem_ack) ? dw_cnt + 1 : 0;
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (dmem_req && dmem_ack && dmem_we) begin
            ram[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic expired(input string name);
        n_chk++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input int base, input bit mem, input bit we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] pc_nxt);
        vec_t v;
        v.pc = pc; v.base = base; v.mem = mem; v.we = we;
        v.addr = addr; v.wdata = wdata; v.pc_nxt = pc_nxt;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_pc", pc_o, RST_PC);
        check("rst_instret", instret_o, 32'd0);
        check("rst_flags", {29'b0, fault_o, halted_o, retire_o}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        n_ret = 0;
        @(negedge clk);
        check("boot_imem_req", {31'b0, imem_req}, 32'd0);
        check("boot_pc", pc_o, RST_PC);
        @(negedge clk);
        check("boot_to_fetch", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic run_one(input vec_t v);
        int cyc;
        cyc = 0;
        while (!imem_req && cyc < 50) begin @(negedge clk); cyc++; end
        check("fetch_addr", imem_addr, v.pc);
        cyc = 1;
        while (!retire_o && cyc < 60) begin
            if (imem_req) check("imem_addr_hold", imem_addr, v.pc);
            if (dmem_req) check("dmem_addr_hold", dmem_addr, v.addr);
            @(negedge clk);
            cyc++;
        end
        if (!retire_o) begin
            expired("retire");
            return;
        end
        check("cycles", 32'(cyc), 32'(v.base + i_wait + (v.mem ? d_wait : 0)));
        if (v.mem) begin
            check("dmem_req", {31'b0, dmem_req}, 32'd1);
            check("dmem_we", {31'b0, dmem_we}, {31'b0, v.we});
            check("dmem_addr", dmem_addr, v.addr);
            if (v.we) check("dmem_wdata", dmem_wdata, v.wdata);
        end
        n_ret++;
        @(negedge clk);
        check("pc_next", pc_o, v.pc_nxt);
        check("instret", instret_o, 32'(n_ret));
    endtask

    initial begin
        int k;
        reset = 1'b1; halt_i = 1'b0; i_wait = 0; d_wait = 0; d_en = 1'b1; d_force = 1'b0;
        n_chk = 0; n_pass = 0; n_ret = 0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
        rom[0]  = 32'h0050_0093;  // addi x1,x0,5
        rom[1]  = 32'h0070_8113;  // addi x2,x1,7
        rom[2]  = 32'h0020_81B3;  // add  x3,x1,x2
        rom[3]  = 32'h0030_2423;  // sw   x3,8(x0)
        rom[4]  = 32'h0080_2203;  // lw   x4,8(x0)
        rom[5]  = 32'h0040_2623;  // sw   x4,12(x0)
        rom[6]  = 32'hFFD0_0313;  // addi x6,x0,-3
        rom[7]  = 32'h4013_5393;  // srai x7,x6,1
        rom[8]  = 32'h0000_0463;  // beq  x0,x0,+8
        rom[9]  = 32'h0000_0393;  // addi x7,x0,0 (skipped)
        rom[10] = 32'h0070_2A23;  // sw   x7,20(x0)
        rom[11] = 32'h00C0_2283;  // lw   x5,12(x0)
        rom[12] = 32'h0050_2823;  // sw   x5,16(x0)
        rom[13] = 32'h1000_2403;  // lw   x8,256(x0)

        tbl[0]  = mk(32'd0,  2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd4);
        tbl[1]  = mk(32'd4,  2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd8);
        tbl[2]  = mk(32'd8,  2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd12);
        tbl[3]  = mk(32'd12, 3, 1'b1, 1'b1, 32'd8,  32'd17,        32'd16);
        tbl[4]  = mk(32'd16, 3, 1'b1, 1'b0, 32'd8,  32'd0,         32'd20);
        tbl[5]  = mk(32'd20, 3, 1'b1, 1'b1, 32'd12, 32'd17,        32'd24);
        tbl[6]  = mk(32'd24, 2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd28);
        tbl[7]  = mk(32'd28, 2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd32);
        tbl[8]  = mk(32'd32, 2, 1'b0, 1'b0, 32'd0,  32'd0,         32'd40);
        tbl[9]  = mk(32'd40, 3, 1'b1, 1'b1, 32'd20, 32'hFFFF_FFFE, 32'd44);
        tbl[10] = mk(32'd48, 3, 1'b1, 1'b1, 32'd16, 32'd17,        32'd52);

        // Zero-wait memories.
        do_reset();
        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // Slow memories: 3 fetch wait cycles, 2 data wait cycles.
        i_wait = 3; d_wait = 2;
        do_reset();
        for (int i = 0; i < 10; i++) run_one(tbl[i]);

        // Halt raised during the load at 44: the load finishes, then the core parks.
        k = 0;
        while (!dmem_req && k < 30) begin @(negedge clk); k++; end
        if (!dmem_req) expired("halt_load_mem");
        halt_i = 1'b1;
        k = 0;
        while (!retire_o && k < 30) begin @(negedge clk); k++; end
        check("halt_load_retire", {31'b0, retire_o}, 32'd1);
        n_ret++;
        @(negedge clk);
        check("halted", {31'b0, halted_o}, 32'd1);
        check("halt_no_req", {30'b0, imem_req, dmem_req}, 32'd0);
        check("halt_pc", pc_o, 32'd48);
        check("halt_instret", instret_o, 32'(n_ret));
        @(negedge clk);
        check("halt_stay", {31'b0, halted_o}, 32'd1);
        halt_i = 1'b0;
        @(negedge clk);
        check("unhalt", {31'b0, halted_o}, 32'd0);
        check("unhalt_fetch", {31'b0, imem_req}, 32'd1);
        check("unhalt_addr", imem_addr, 32'd48);
        run_one(tbl[10]);

        // Data memory never answers the load at 52.
        d_en = 1'b0;
        k = 0;
        while (!dmem_req && k < 30) begin @(negedge clk); k++; end
        if (!dmem_req) expired("tmo_mem");
        for (int c = 0; c < 4; c++) begin
            check("tmo_wait_req", {31'b0, dmem_req}, 32'd1);
            check("tmo_wait_fault", {31'b0, fault_o}, 32'd0);
            @(negedge clk);
        end
        check("tmo_fault", {31'b0, fault_o}, 32'd1);
        check("tmo_no_req", {30'b0, imem_req, dmem_req}, 32'd0);
        check("tmo_pc", pc_o, 32'd52);
        check("tmo_instret", instret_o, 32'(n_ret));
        d_force = 1'b1; d_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_fault", {31'b0, fault_o}, 32'd1);
            check("late_ack_pc", pc_o, 32'd52);
            check("late_ack_retire", {31'b0, retire_o}, 32'd0);
        end
        d_force = 1'b0;

        // Reset out of FAULT, then abort the store at 12 while it waits in MEM.
        i_wait = 0; d_wait = 3;
        do_reset();
        for (int i = 0; i < 3; i++) run_one(tbl[i]);
        k = 0;
        while (!dmem_req && k < 30) begin @(negedge clk); k++; end
        check("abort_in_mem", {31'b0, dmem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("abort_dmem_we", {31'b0, dmem_we}, 32'd0);
        check("abort_retire", {31'b0, retire_o}, 32'd0);
        check("abort_pc", pc_o, RST_PC);
        do_reset();
        check("abort_ram_untouched", ram[2], 32'd0);
        d_wait = 0;
        for (int i = 0; i < 5; i++) run_one(tbl[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
